sdp_sram: RTL and testbench
===========================

# sdp_sram

Simple dual-port on-chip SRAM for the GEMM datapath: one write port and one read port per cycle, with byte-granular write strobes and a configurable read pipeline depth. After every reset, a hardware sweep clears the whole array, so operand and accumulator buffers start from zero without software. The block replaces the single-port scratchpad wherever a producer and a consumer must touch the same buffer in the same cycle.

## Interface
- ADDR_WIDTH, 10, word address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8.
- READ_LATENCY, 1, rd_en-to-rd_valid cycles. Legal values are 1 and 2; any other value is a fatal elaboration error.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- init_busy  output  1  high while the post-reset clear sweep runs.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write word address.
- wr_data  input  DATA_WIDTH  write data.
- wr_strb  input  DATA_WIDTH/8  byte enables; bit i controls wr_data[8i+7:8i].
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read word address.
- rd_data  output  DATA_WIDTH  read data, qualified by rd_valid.
- rd_valid  output  1  one-cycle pulse per accepted read.

## Operation
- State machine with two states, INIT and READY. Reset forces INIT and sets clear counter clr_addr=0.
- INIT:
  - Each cycle writes all-zero to memory[clr_addr] and increments clr_addr.
  - After the cycle that clears address DEPTH-1, the state moves to READY.
  - wr_en and rd_en are ignored; no read is accepted and the array is not otherwise modified.
- READY:
  - Write: if wr_en is high, each byte i with wr_strb[i]=1 is updated. Bytes with wr_strb[i]=0 are unchanged. wr_strb=0 is a legal no-op.
  - Read: if rd_en is high, the read is accepted and the word at rd_addr is returned after READY_LATENCY cycles. One read can be accepted every cycle; the pipeline is fully overlapped.
- Read/write collision: wr_en and rd_en in the same cycle with wr_addr==rd_addr. The result is set by the build option in Configuration.
- rd_data holds its last value between reads. rd_valid is high only for the cycle carrying a result.
- Reset asserted mid-operation:
  - The sweep restarts from address 0.
  - All in-flight reads are discarded; no rd_valid pulse is issued for them.
  - rd_data and rd_valid go to 0 immediately (asynchronous).
- Reset values: init_busy=1, rd_data=0, rd_valid=0, state=INIT, clr_addr=0, pipeline stage valid bits=0.

## Timing
- Sweep length: reset deasserts before edge 0. Edges 0..DEPTH-1 clear addresses 0..DEPTH-1. init_busy is high through edge DEPTH-1 and low after edge DEPTH-1.
- The first accepted access is sampled at edge DEPTH.
- READY_LATENCY=1: rd_en sampled at edge N gives rd_data/rd_valid updated at edge N, visible during cycle N..N+1.
- READY_LATENCY=2: the array output register is followed by one extra output register. The result appears at edge N+1.
- A write sampled at edge N is visible to any read sampled at edge N+1 or later, for either latency.
- init_busy and rd_valid are registered outputs. The block has no combinational path from any input to any output.

## Configuration
- SDP_SRAM_BYPASS_EN defined: a collision returns the merged word. Bytes with wr_strb set come from wr_data; the other bytes are the old contents. This is write-first behaviour.
- SDP_SRAM_BYPASS_EN undefined: a collision returns the old contents of the word (read-first). The write still completes normally.
- No other behaviour depends on the macro.

## Test plan
- Init sweep, ADDR_WIDTH=4:
  - Release reset, then pulse rd_en during INIT: init_busy is high for exactly 16 cycles and no rd_valid appears.
  - Write 0xFFFFFFFF during INIT: it is ignored.
  - Afterwards, reads of addresses 0..15 all return 0x00000000.
- Latency, both READY_LATENCY values:
  - Write 0xDEADBEEF to address 5, then read address 5 one cycle later.
  - Required: rd_valid exactly 1 or 2 cycles after rd_en, with rd_data=0xDEADBEEF.
  - Back-to-back reads of addresses 0..3 produce 4 consecutive rd_valid pulses, in order.
- Byte strobes:
  - Write 0x11223344 with strb=0xF, then 0xAABBCCDD with strb=0x5, to address 7.
  - Required: a read returns 0x11BB33DD. A write with strb=0x0 leaves the word unchanged.
- Collision, address 3 holding 0x01020304:
  - Same-cycle write of 0xA0B0C0D0 with strb=0x3 and read of address 3.
  - Required: 0x0102C0D0 with SDP_SRAM_BYPASS_EN defined, 0x01020304 without it.
  - A following read returns 0x0102C0D0 in both builds.
- Reset mid-operation:
  - Assert reset_n low with two reads in flight (READY_LATENCY=2).
  - Required: rd_valid and rd_data drop to 0 at once, no stale pulse appears after release, and the sweep reruns for 2^ADDR_WIDTH cycles.
  - Previously written data reads back as 0.

Source files
------------

// File: rtl/sdp_sram.sv
// Simple dual-port SRAM: one byte-strobed write port, one read port, post-reset zero sweep.
// Build option SDP_SRAM_BYPASS_EN selects write-first collision behaviour (default read-first).
module sdp_sram #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    init_busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned NBYTE = DATA_WIDTH / 8;

    typedef enum logic {INIT, READY} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    clr_we;
    logic                    init_busy_d;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NBYTE-1:0]        mem_strb;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            clr_addr  <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= next_state;
            init_busy <= init_busy_d;
            if (clr_we)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (clr_addr == '1) next_state = READY;
            READY:   next_state = READY;
            default: next_state = INIT;
        endcase
    end

    always_comb begin
        clr_we      = (state == INIT);
        init_busy_d = (next_state == INIT);
        wr_accept   = (state == READY) && wr_en;
        rd_accept   = (state == READY) && rd_en;
    end

    // The clear sweep owns the write port during INIT.
    always_comb begin
        mem_we    = clr_we || wr_accept;
        mem_addr  = clr_we ? clr_addr : wr_addr;
        mem_wdata = clr_we ? '0 : wr_data;
        mem_strb  = clr_we ? '1 : wr_strb;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                if (mem_strb[i])
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef SDP_SRAM_BYPASS_EN
        if (wr_accept && (wr_addr == rd_addr)) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                if (wr_strb[i])
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
`endif
    end

    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= rd_accept;
                if (rd_accept)
                    rd_data <= rd_word;
            end
        end
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic                  stage_valid;
        logic [DATA_WIDTH-1:0] stage_data;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_valid <= 1'b0;
                stage_data  <= '0;
                rd_valid    <= 1'b0;
                rd_data     <= '0;
            end else begin
                stage_valid <= rd_accept;
                if (rd_accept)
                    stage_data <= rd_word;
                rd_valid <= stage_valid;
                if (stage_valid)
                    rd_data <= stage_data;
            end
        end
    end else begin : g_bad_latency
        $fatal(1, "sdp_sram: READ_LATENCY must be 1 or 2");
    end

endmodule

// File: tb/tb_sdp_sram.sv
// Directed bench for sdp_sram: two instances (read latency 1 and 2) share one stimulus stream.
module tb_sdp_sram;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        busy1, busy2, v1, v2;
    logic [31:0] d1, d2;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SDP_SRAM_BYPASS_EN
    localparam logic [31:0] COLEXP = 32'h0102C0D0;
`else
    localparam logic [31:0] COLEXP = 32'h01020304;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        re;
        logic [3:0]  ra;
        logic        ev1;
        logic [31:0] ed1;
        logic        ev2;
        logic [31:0] ed2;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sdp_sram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .init_busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1)
    );

    sdp_sram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .init_busy(busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2)
    );

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd, logic [3:0] ws,
                                logic re, logic [3:0] ra, logic ev1, logic [31:0] ed1,
                                logic ev2, logic [31:0] ed2);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.ws = ws; r.re = re; r.ra = ra;
        r.ev1 = ev1; r.ed1 = ed1; r.ev2 = ev2; r.ed2 = ed2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        wr_en = r.we; wr_addr = r.wa; wr_data = r.wd; wr_strb = r.ws;
        rd_en = r.re; rd_addr = r.ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requests during the sweep must be ignored; writes target address 0, already cleared at edge 0.
    task automatic sweep(input string tag);
        int busy_cnt = 0;
        chk({tag, " busy pre-edge0"}, {31'd0, busy1}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (busy1) busy_cnt++;
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
            rd_en = 1'b1; rd_addr = 4'(i);
            step();
            chk($sformatf("%s edge%0d v1", tag, i), {31'd0, v1}, 32'd0);
            chk($sformatf("%s edge%0d v2", tag, i), {31'd0, v2}, 32'd0);
            chk($sformatf("%s edge%0d busy1", tag, i), {31'd0, busy1}, {31'd0, (i < 15)});
            chk($sformatf("%s edge%0d busy2", tag, i), {31'd0, busy2}, {31'd0, (i < 15)});
        end
        chk({tag, " busy cycles"}, busy_cnt, 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 4'(i), 1, 0, (i > 0), 0));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 4'(i), 32'hC0DE0000 + i, 4'hF, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 4'(i), 1, 32'hC0DE0000 + i,
                             (i > 0), (i > 0) ? 32'hC0DE0000 + i - 1 : 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hC0DE0003, 1, 32'hC0DE0003));
        tbl.push_back(mk(1, 7, 32'h11223344, 4'hF, 0, 0, 0, 32'hC0DE0003, 0, 32'hC0DE0003));
        tbl.push_back(mk(1, 7, 32'hAABBCCDD, 4'h5, 0, 0, 0, 32'hC0DE0003, 0, 32'hC0DE0003));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 1, 32'h11BB33DD, 0, 32'hC0DE0003));
        tbl.push_back(mk(1, 7, 32'hFFFFFFFF, 4'h0, 1, 7, 1, 32'h11BB33DD, 1, 32'h11BB33DD));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 1, 32'h11BB33DD, 1, 32'h11BB33DD));
        tbl.push_back(mk(1, 3, 32'h01020304, 4'hF, 0, 0, 0, 32'h11BB33DD, 1, 32'h11BB33DD));
        tbl.push_back(mk(1, 3, 32'hA0B0C0D0, 4'h3, 1, 3, 1, COLEXP, 0, 32'h11BB33DD));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 32'h0102C0D0, 1, COLEXP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0102C0D0, 1, 32'h0102C0D0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 1, 32'hDEADBEEF, 0, 32'h0102C0D0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 1, 32'h11BB33DD, 1, 32'hDEADBEEF));

        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        chk("reset busy1", {31'd0, busy1}, 32'd1);
        chk("reset busy2", {31'd0, busy2}, 32'd1);
        chk("reset v1", {31'd0, v1}, 32'd0);
        chk("reset v2", {31'd0, v2}, 32'd0);
        chk("reset d1", d1, 32'd0);
        chk("reset d2", d2, 32'd0);

        reset_n = 1'b1;
        sweep("init");

        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            chk($sformatf("row%0d v1", i), {31'd0, v1}, {31'd0, tbl[i].ev1});
            chk($sformatf("row%0d d1", i), d1, tbl[i].ed1);
            chk($sformatf("row%0d v2", i), {31'd0, v2}, {31'd0, tbl[i].ev2});
            chk($sformatf("row%0d d2", i), d2, tbl[i].ed2);
        end

        // Read of address 7 is still in the latency-2 stage when reset hits.
        reset_n = 1'b0;
        #1;
        chk("midrst v1", {31'd0, v1}, 32'd0);
        chk("midrst d1", d1, 32'd0);
        chk("midrst v2", {31'd0, v2}, 32'd0);
        chk("midrst d2", d2, 32'd0);
        chk("midrst busy2", {31'd0, busy2}, 32'd1);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rsthold%0d v2", i), {31'd0, v2}, 32'd0);
        end
        reset_n = 1'b1;
        sweep("resweep");

        drive(mk(0, 0, 0, 0, 1, 5, 0, 0, 0, 0));
        step();
        chk("post rd5 v1", {31'd0, v1}, 32'd1);
        chk("post rd5 d1", d1, 32'd0);
        chk("post rd5 v2 early", {31'd0, v2}, 32'd0);
        drive(mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        step();
        chk("post rd7 v1", {31'd0, v1}, 32'd1);
        chk("post rd7 d1", d1, 32'd0);
        chk("post rd5 v2", {31'd0, v2}, 32'd1);
        chk("post rd5 d2", d2, 32'd0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk("post idle v1", {31'd0, v1}, 32'd0);
        chk("post rd7 v2", {31'd0, v2}, 32'd1);
        chk("post rd7 d2", d2, 32'd0);
        step();
        chk("post idle v2", {31'd0, v2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
